// File: rtl/bus_master_arbiter_if.sv
// Bus bundle between the four requesting masters, the arbiter and the single slave.
// The "master" modport is the arbiter's view (it masters the slave); "slave" is the environment's view.
interface bus_master_arbiter_if;
    logic [3:0]   master_rreq;
    logic [3:0]   master_wreq;
    logic [3:0]   master_lock;
    logic [127:0] master_addr;
    logic [127:0] master_wdata;
    logic [31:0]  master_rdata;
    logic [3:0]   master_acc;
    logic [3:0]   master_err;
    logic         master_busy;
    logic [1:0]   master_grant;
    logic         slave_rreq;
    logic         slave_wreq;
    logic [31:0]  slave_addr;
    logic [31:0]  slave_wdata;
    logic [31:0]  slave_rdata;
    logic         slave_ack;

    modport master (
        input  master_rreq, master_wreq, master_lock, master_addr, master_wdata,
               slave_rdata, slave_ack,
        output master_rdata, master_acc, master_err, master_busy, master_grant,
               slave_rreq, slave_wreq, slave_addr, slave_wdata
    );

    modport slave (
        output master_rreq, master_wreq, master_lock, master_addr, master_wdata,
               slave_rdata, slave_ack,
        input  master_rdata, master_acc, master_err, master_busy, master_grant,
               slave_rreq, slave_wreq, slave_addr, slave_wdata
    );
endinterface

// File: rtl/bus_master_arbiter.sv
// Four-master round-robin bus arbiter with optional grant lock, single-word slave
// transactions and a watchdog that aborts a transfer the slave never acknowledges.
module bus_master_arbiter #(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int CNT_W          = 10
) (
    input logic             clk,
    input logic             reset,
    bus_master_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_reg, state_next;
    logic [1:0]       last_reg, last_next;
    logic [1:0]       grant_reg, grant_next;
    logic [1:0]       lock_id_reg, lock_id_next;
    logic             lock_valid_reg, lock_valid_next;
    logic             write_reg, write_next;
    logic [31:0]      addr_reg, addr_next;
    logic [31:0]      wdata_reg, wdata_next;
    logic [31:0]      rdata_reg, rdata_next;
    logic             err_reg, err_next;
    logic [CNT_W-1:0] wdog_reg, wdog_next;

    logic [3:0]  req;
    logic [31:0] addr_arr  [4];
    logic [31:0] wdata_arr [4];
    logic [3:0]  acc_vec;
    logic [3:0]  err_vec;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_master
            assign addr_arr[gi]  = bus.master_addr[32*gi +: 32];
            assign wdata_arr[gi] = bus.master_wdata[32*gi +: 32];
            assign req[gi]       = bus.master_rreq[gi] | bus.master_wreq[gi];
            assign acc_vec[gi]   = (state_reg == ST_DONE) && (grant_reg == 2'(gi));
            assign err_vec[gi]   = acc_vec[gi] & err_reg;
        end
    endgenerate

    // Round-robin winner: first requester after the last granted master.
    logic       rr_found;
    logic [1:0] rr_idx;
    logic [1:0] rr_cand;
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = last_reg;
        rr_cand  = last_reg;
        for (int k = 1; k <= 4; k++) begin
            rr_cand = last_reg + 2'(k);
            if (!rr_found && req[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            last_reg       <= 2'd3;
            grant_reg      <= 2'd0;
            lock_id_reg    <= 2'd0;
            lock_valid_reg <= 1'b0;
            write_reg      <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            rdata_reg      <= '0;
            err_reg        <= 1'b0;
            wdog_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            last_reg       <= last_next;
            grant_reg      <= grant_next;
            lock_id_reg    <= lock_id_next;
            lock_valid_reg <= lock_valid_next;
            write_reg      <= write_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            rdata_reg      <= rdata_next;
            err_reg        <= err_next;
            wdog_reg       <= wdog_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        last_next       = last_reg;
        grant_next      = grant_reg;
        lock_id_next    = lock_id_reg;
        lock_valid_next = lock_valid_reg;
        write_next      = write_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        rdata_next      = rdata_reg;
        err_next        = err_reg;
        wdog_next       = wdog_reg;

        unique case (state_reg)
            ST_IDLE: begin
                if (lock_valid_reg && req[lock_id_reg]) begin
                    grant_next = lock_id_reg;
                    state_next = ST_ISSUE;
                end else if (rr_found) begin
                    grant_next = rr_idx;
                    state_next = ST_ISSUE;
                end
                if (state_next == ST_ISSUE) begin
                    addr_next  = addr_arr[grant_next];
                    wdata_next = wdata_arr[grant_next];
                    write_next = bus.master_wreq[grant_next];
                end
            end
            ST_ISSUE: begin
                wdog_next = '0;
                if (bus.slave_ack) begin
                    rdata_next = write_reg ? 32'd0 : bus.slave_rdata;
                    err_next   = 1'b0;
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A real ack wins over a watchdog expiry landing in the same cycle.
                if (bus.slave_ack) begin
                    rdata_next = write_reg ? 32'd0 : bus.slave_rdata;
                    err_next   = 1'b0;
                    state_next = ST_DONE;
                end else if (wdog_reg == WDOG_LAST) begin
                    rdata_next = 32'd0;
                    err_next   = 1'b1;
                    state_next = ST_DONE;
                end else begin
                    wdog_next = wdog_reg + 1'b1;
                end
            end
            ST_DONE: begin
                last_next       = grant_reg;
                lock_valid_next = bus.master_lock[grant_reg];
                lock_id_next    = grant_reg;
                state_next      = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.master_acc   = acc_vec;
    assign bus.master_err   = err_vec;
    assign bus.master_rdata = (state_reg == ST_DONE) ? rdata_reg : 32'd0;
    assign bus.master_busy  = (state_reg != ST_IDLE);
    assign bus.master_grant = grant_reg;
    assign bus.slave_rreq   = (state_reg == ST_ISSUE) && !write_reg;
    assign bus.slave_wreq   = (state_reg == ST_ISSUE) && write_reg;
    assign bus.slave_addr   = addr_reg;
    assign bus.slave_wdata  = wdata_reg;

endmodule

// File: doc/bus_master_arbiter.md
Name: bus_master_arbiter

Overview:
- Arbitrates the shared system bus between four masters: L2 cache on port 0, direct loader on port 1, ports 2-3 spare.
- Grants one master at a time with round-robin priority and an optional per-master lock for back-to-back transfers.
- Issues a single-word transaction to the slave side and waits for the slave acknowledge, under watchdog protection.
- Returns read data, completion and error to the granted master.

Parameters:
TIMEOUT_CYCLES, 1023, maximum WAIT cycles before a transaction is aborted with error; must be below 2**CNT_W.
CNT_W, 10, width of the watchdog counter.

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
master_rreq  input  4  per-master read request; held until its master_acc bit
master_wreq  input  4  per-master write request; held until its master_acc bit
master_lock  input  4  per-master request to keep the grant for its next transfer
master_addr  input  128  packed addresses; master i uses bits [32*i+31:32*i]
master_wdata  input  128  packed write data, same packing as master_addr
master_rdata  output  32  read data for the granted master; valid while master_acc is high
master_acc  output  4  one-cycle completion pulse to the granted master
master_err  output  4  timeout flag; valid in the same cycle as master_acc
master_busy  output  1  high whenever state is not IDLE
master_grant  output  2  index of the current or last granted master
slave_rreq  output  1  one-cycle read strobe
slave_wreq  output  1  one-cycle write strobe
slave_addr  output  32  latched address of the granted master
slave_wdata  output  32  latched write data of the granted master
slave_rdata  input  32  slave read data; valid while slave_ack is high
slave_ack  input  1  one-cycle slave completion pulse

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All outputs 0.
  - Round-robin pointer last=3, so master 0 has first priority.
  - Lock holder cleared; watchdog counter 0.
- A master requests when (rreq|wreq) is high for it. If rreq and wreq are both high, the request is treated as a write.
- IDLE:
  - No requester: remain in IDLE.
  - A valid lock holder exists and it is requesting: grant it.
  - Otherwise: grant the first requester scanning last+1, last+2, ... modulo 4.
  - On a grant, latch grant index, addr, wdata and op (read/write), then go to ISSUE.
- ISSUE (exactly one cycle):
  - Assert slave_rreq or slave_wreq.
  - slave_addr and slave_wdata hold the latched values and stay stable until the next grant.
  - Watchdog cleared.
  - If slave_ack is sampled high this cycle, go to DONE with rdata captured. Otherwise go to WAIT.
- WAIT:
  - Strobes low; watchdog increments every cycle.
  - If slave_ack=1: capture slave_rdata (writes capture 0), err=0, go to DONE.
  - Else if watchdog==TIMEOUT_CYCLES-1: rdata=0, err=1, go to DONE.
  - slave_ack has priority over timeout when both occur in the same cycle.
- DONE (exactly one cycle):
  - master_acc[grant]=1, master_rdata=captured data, master_err[grant]=err.
  - Update last=grant.
  - If master_lock[grant]=1 this cycle, that master becomes the lock holder; otherwise the lock holder is cleared.
  - Go to IDLE.
  - The master must drop its request by the next edge; IDLE samples the request after that edge.
- Latency with zero-wait slave (ack in ISSUE): request sampled in IDLE at cycle 0, strobe at cycle 1, acc at cycle 2.
- Bus occupancy and throughput:
  - master_busy=1 in ISSUE, WAIT and DONE.
  - Minimum spacing is one transaction per 3 cycles.
- Ignored and unchanged inputs:
  - slave_ack is ignored in IDLE and DONE; a late ack after a timeout is discarded.
  - Request, addr and wdata changes after the grant is latched have no effect on the transaction in flight.
  - A lock from a non-granted master has no effect.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs 0; no acc is produced for the aborted transfer.

Test Plan:
- Single read: master 1 rreq, addr=0x0000_8004; slave acks 2 cycles after strobe with 0xDEADBEEF -> slave_rreq one cycle with addr 0x0000_8004; master_acc=4'b0010 with rdata 0xDEADBEEF, err=0; master_busy falls the cycle after acc.
- Round-robin: all four masters request continuously (each re-requests after its acc), zero-wait slave -> grant order 0,1,2,3,0; acc pulses every 3 cycles.
- Lock: masters 0 and 2 request, master 0 holds lock=1 for 3 transfers -> grants 0,0,0, then 2 after lock drops; master 2 is never granted while 0 holds the lock and requests.
- Timeout: master 0 wreq, wdata=0x12345678, slave never acks, TIMEOUT_CYCLES=8 -> acc and err[0] in the DONE cycle following the 8th WAIT cycle; rdata=0; a slave_ack injected 3 cycles later is ignored and master_busy stays 0.
- Ack/timeout collision and rreq+wreq: ack on the final WAIT cycle -> err=0 with data; master 3 with both rreq and wreq -> only slave_wreq pulses.
- Reset mid-WAIT: reset driven low during WAIT -> outputs 0 asynchronously, no acc produced; after release with masters 0 and 3 requesting, master 0 is granted first.
